// File: rtl/fb_access_arbiter.sv
// Framebuffer access arbiter: scan-out wins during active video,
// hosts A/B share the RAM round-robin otherwise.
module fb_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blank,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_SCAN = 2'd1,
    SRC_A    = 2'd2,
    SRC_B    = 2'd3
  } src_e;

  src_e win;
  src_e tag1_d, tag1_q;
  src_e tag2_d, tag2_q;

  logic a_elig, b_elig;
  logic last_b_d, last_b_q;

  logic              mem_en_d, mem_en_q;
  logic              mem_we_d, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;

  logic a_ack_d, a_ack_q;
  logic b_ack_d, b_ack_q;

  logic              scan_valid_d, scan_valid_q;
  logic              a_rvalid_d, a_rvalid_q;
  logic              b_rvalid_d, b_rvalid_q;
  logic [DATA_W-1:0] scan_data_d, scan_data_q;
  logic [DATA_W-1:0] a_rdata_d, a_rdata_q;
  logic [DATA_W-1:0] b_rdata_d, b_rdata_q;

  // A host whose ack is high is masked so a held req is not granted twice
  always_comb begin
    a_elig = a_req & ~a_ack_q;
    b_elig = b_req & ~b_ack_q;
    win    = SRC_NONE;
    if (scan_req && !blank) begin
      win = SRC_SCAN;
    end else if (a_elig && b_elig) begin
      win = last_b_q ? SRC_A : SRC_B;
    end else if (a_elig) begin
      win = SRC_A;
    end else if (b_elig) begin
      win = SRC_B;
    end else if (scan_req) begin
      win = SRC_SCAN;
    end
  end

  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    last_b_d    = last_b_q;
    tag1_d      = SRC_NONE;
    case (win)
      SRC_SCAN: begin
        mem_en_d   = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = scan_addr;
        tag1_d     = SRC_SCAN;
      end
      SRC_A: begin
        mem_en_d    = 1'b1;
        mem_we_d    = a_we;
        mem_addr_d  = a_addr;
        mem_wdata_d = a_wdata;
        a_ack_d     = 1'b1;
        last_b_d    = 1'b0;
        tag1_d      = a_we ? SRC_NONE : SRC_A;
      end
      SRC_B: begin
        mem_en_d    = 1'b1;
        mem_we_d    = b_we;
        mem_addr_d  = b_addr;
        mem_wdata_d = b_wdata;
        b_ack_d     = 1'b1;
        last_b_d    = 1'b1;
        tag1_d      = b_we ? SRC_NONE : SRC_B;
      end
      SRC_NONE: ;
    endcase
  end

  // Read return: tag reaches stage 2 as the RAM output becomes valid
  always_comb begin
    tag2_d       = tag1_q;
    scan_valid_d = (tag2_q == SRC_SCAN);
    a_rvalid_d   = (tag2_q == SRC_A);
    b_rvalid_d   = (tag2_q == SRC_B);
    scan_data_d  = scan_valid_d ? mem_rdata : scan_data_q;
    a_rdata_d    = a_rvalid_d ? mem_rdata : a_rdata_q;
    b_rdata_d    = b_rvalid_d ? mem_rdata : b_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag1_q       <= SRC_NONE;
      tag2_q       <= SRC_NONE;
      last_b_q     <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      scan_valid_q <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      scan_data_q  <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      last_b_q     <= last_b_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      scan_valid_q <= scan_valid_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      scan_data_q  <= scan_data_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign scan_valid = scan_valid_q;
  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign scan_data  = scan_data_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;

endmodule
